integrador_multicanal: RTL and testbench
========================================

// Module: integrador_multicanal
// PURPOSE
//  N-channel parametrised integrator: v[ch] <= v[ch] + ((a[ch]*dt) >>> SHIFT), one op per start.
//  Multiply is an internal radix-2 shift-add, time-shared across channels (no external multiplier).
//  Sits between the IMU sample registers and the position stage; feeding v back as a gives a double integral.
//  Adds over the single-channel integrator: channels, widths, fixed-point shift, saturation,
//  overflow flags, clear, one-cycle done pulse.
// PARAMETERS
//  N_CH   2   number of channels (>=1)
//  A_W    16  signed input sample width per channel
//  DT_W   16  unsigned time-step width; also the multiply cycle count per channel
//  ACC_W  32  signed accumulator/output width per channel (>= A_W+DT_W-SHIFT)
//  SHIFT  0   arithmetic right shift applied to each product (fixed-point scaling)
//  SAT    1   1 = saturate to +/-(2^(ACC_W-1)-1 / -2^(ACC_W-1)); 0 = two's-complement wrap
// PORTS
//  clk     in   1           clock; all logic on posedge
//  rst     in   1           synchronous, active-high reset
//  enable  in   1           start request; accepted only when busy=0
//  clear   in   1           zero all accumulators; honoured only when busy=0
//  a       in   N_CH*A_W    packed signed samples, channel 0 in LSBs
//  dt      in   DT_W        unsigned time step, shared by all channels
//  v       out  N_CH*ACC_W  packed signed integrals, registered
//  ovf     out  N_CH        per-channel saturate/wrap flag from the last completed op
//  busy    out  1           high from the accept edge until the edge after done
//  done    out  1           one-cycle pulse, v/ovf valid in the same cycle
// BEHAVIOUR
//  Reset: v=0, ovf=0, busy=0, done=0, internal accumulators=0, state=IDLE. Applies mid-op too:
//   the op is abandoned, no done pulse is issued, and v reads 0 from the next cycle.
//  States: IDLE -> MUL -> ACC -> (MUL for next ch | DONE) -> IDLE.
//  IDLE: if clear=1, accumulators and v go to 0 and ovf goes to 0. clear beats enable; enable is dropped that cycle.
//   Else if enable=1, a and dt are latched, ch=0, busy goes to 1, and the state moves to MUL.
//  MUL: DT_W cycles; each cycle tests one dt bit (LSB first) and adds the sign-extended a[ch]<<bit.
//   The product is signed and A_W+DT_W bits wide. dt=0 still takes DT_W cycles.
//  ACC: 1 cycle; sum = acc[ch] + (product >>> SHIFT), computed ACC_W+1 bits wide.
//   On overflow: SAT=1 clamps to the limit, SAT=0 keeps the low ACC_W bits. In both cases ovf_next[ch]=1.
//   If ch<N_CH-1, then ch++ and the state moves to MUL; else it moves to DONE.
//  DONE: 1 cycle; done=1, and v and ovf hold the committed values.
//   v and ovf are copied from the accumulators on the ACC->DONE edge, so all channels update atomically.
//   Next edge: IDLE, busy=0.
//  Latency: done is high exactly N_CH*(DT_W+1) cycles after the accept edge. Back-to-back restart period is N_CH*(DT_W+1)+2.
//  enable/clear/a/dt while busy: ignored; there is no queue. Inputs are sampled only at accept.
//  enable held high: a new op is accepted on the first IDLE cycle after done.
//  v is stable between done pulses; ovf is not sticky and is recomputed on every op.
// TESTING (N_CH=2, A_W=16, DT_W=16, ACC_W=32, SHIFT=0 unless stated)
//  T1 basic: a0=3, a1=-5, dt=10, enable 1 cycle -> done at +34 cycles; v0=30, v1=-50, ovf=00; busy high for 35 cycles.
//  T2 accumulate: repeat T1 -> v0=60, v1=-100; enable held high -> third op starts on the cycle after busy drops.
//  T3 saturate: SAT=1, a0=0x7FFF, dt=0xFFFF, two ops -> op1 v0=0x7FFE8001; op2 v0=0x7FFFFFFF, ovf[0]=1.
//   SAT=0 -> op2 v0=0xFFFD0002, ovf[0]=1; a third op with a=0 -> ovf=0.
//  T4 reset mid-op: rst=1 on the 10th busy cycle -> next cycle busy=0, v=0, ovf=0; no done pulse.
//   A following enable behaves like T1.
//  T5 clear/enable priority: in IDLE with v0=30, clear=1 and enable=1 together -> v=0, busy stays 0.
//   clear or enable during busy -> no effect.
//  T6 shift: SHIFT=4, N_CH=1, a=16, dt=1 -> v=1. Then a=-1, dt=1 -> v=0 (1 + (-1>>>4 = -1)).

Source files
------------

// File: rtl/integrador_multicanal_if.sv
// Request/result bundle for integrador_multicanal: start/clear request, packed samples
// and time step in; packed integrals, overflow flags and status out.
interface integrador_multicanal_if #(
    parameter int N_CH  = 2,
    parameter int A_W   = 16,
    parameter int DT_W  = 16,
    parameter int ACC_W = 32
);
    logic                    enable;
    logic                    clear;
    logic [N_CH*A_W-1:0]     a;
    logic [DT_W-1:0]         dt;
    logic [N_CH*ACC_W-1:0]   v;
    logic [N_CH-1:0]         ovf;
    logic                    busy;
    logic                    done;

    modport master (output enable, clear, a, dt, input v, ovf, busy, done);
    modport slave  (input enable, clear, a, dt, output v, ovf, busy, done);
endinterface

// File: rtl/integrador_multicanal.sv
// N-channel integrator v[ch] += (a[ch]*dt) >>> SHIFT using one time-shared radix-2
// shift-add multiplier; optional saturation, per-channel overflow flags, clear and done pulse.
module integrador_multicanal #(
    parameter int N_CH  = 2,
    parameter int A_W   = 16,
    parameter int DT_W  = 16,
    parameter int ACC_W = 32,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    integrador_multicanal_if.slave bus
);
    localparam int P_W   = A_W + DT_W;
    localparam int EXT_W = (P_W > ACC_W + 1) ? P_W : ACC_W + 1;
    localparam int BIT_W = (DT_W > 1) ? $clog2(DT_W) : 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [BIT_W-1:0]       BIT_LAST = BIT_W'(DT_W - 1);
    localparam logic [CH_W-1:0]        CH_LAST  = CH_W'(N_CH - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                   state_q;
    logic [CH_W-1:0]          ch_q;
    logic [BIT_W-1:0]         bit_q;
    logic [DT_W-1:0]          dt_q;
    logic signed [A_W-1:0]    a_q   [N_CH];
    logic signed [ACC_W-1:0]  acc_q [N_CH];
    logic signed [P_W-1:0]    prod_q, prod_d;
    logic [N_CH-1:0]          ovf_acc_q;
    logic [N_CH*ACC_W-1:0]    v_q, v_d;
    logic [N_CH-1:0]          ovf_q, ovf_d;
    logic                     busy_q, done_q;

    logic signed [EXT_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     ovf_now;

    always_comb begin
        prod_d = prod_q;
        if (dt_q[bit_q]) begin
            prod_d = prod_q + (P_W'(a_q[ch_q]) <<< bit_q);
        end

        // Operands fit in ACC_W signed bits, so the sum fits in ACC_W+1 and bit ACC_W is its sign.
        sum     = EXT_W'(acc_q[ch_q]) + EXT_W'(prod_q >>> SHIFT);
        ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d   = sum[ACC_W-1:0];
        if (ovf_now && (SAT != 0)) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end

        v_d   = '0;
        ovf_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            v_d[i*ACC_W +: ACC_W] = (CH_W'(i) == ch_q) ? acc_d   : acc_q[i];
            ovf_d[i]              = (CH_W'(i) == ch_q) ? ovf_now : ovf_acc_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            bit_q     <= '0;
            dt_q      <= '0;
            prod_q    <= '0;
            ovf_acc_q <= '0;
            v_q       <= '0;
            ovf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                a_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.clear) begin
                        v_q   <= '0;
                        ovf_q <= '0;
                        for (int unsigned i = 0; i < N_CH; i++) acc_q[i] <= '0;
                    end else if (bus.enable) begin
                        for (int unsigned i = 0; i < N_CH; i++) a_q[i] <= bus.a[i*A_W +: A_W];
                        dt_q    <= bus.dt;
                        ch_q    <= '0;
                        bit_q   <= '0;
                        prod_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= prod_d;
                    if (bit_q == BIT_LAST) begin
                        bit_q   <= '0;
                        state_q <= ACC;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                ACC: begin
                    acc_q[ch_q]     <= acc_d;
                    ovf_acc_q[ch_q] <= ovf_now;
                    prod_q          <= '0;
                    if (ch_q == CH_LAST) begin
                        // All channels publish together from the post-ACC image.
                        v_q     <= v_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= MUL;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.v    = v_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_integrador_multicanal.sv
// Directed bench for integrador_multicanal: saturating and wrapping 2-channel instances
// share stimulus; a 1-channel SHIFT=4 instance covers fixed-point scaling.
module tb_integrador_multicanal;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    integrador_multicanal_if #(.N_CH(2), .A_W(16), .DT_W(16), .ACC_W(32)) bus ();
    integrador_multicanal_if #(.N_CH(2), .A_W(16), .DT_W(16), .ACC_W(32)) busw ();
    integrador_multicanal_if #(.N_CH(1), .A_W(16), .DT_W(16), .ACC_W(32)) bs ();

    assign busw.enable = bus.enable;
    assign busw.clear  = bus.clear;
    assign busw.a      = bus.a;
    assign busw.dt     = bus.dt;

    integrador_multicanal #(.N_CH(2), .A_W(16), .DT_W(16), .ACC_W(32), .SHIFT(0), .SAT(1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    integrador_multicanal #(.N_CH(2), .A_W(16), .DT_W(16), .ACC_W(32), .SHIFT(0), .SAT(0))
        dut_w (.clk(clk), .rst(rst), .bus(busw));
    integrador_multicanal #(.N_CH(1), .A_W(16), .DT_W(16), .ACC_W(32), .SHIFT(4), .SAT(1))
        dut_s (.clk(clk), .rst(rst), .bus(bs));

    typedef struct {
        logic [63:0] v_sat;
        logic [63:0] v_wrap;
        logic [1:0]  ovf_sat;
        logic [1:0]  ovf_wrap;
    } exp_t;

    exp_t   sb[$];
    longint sbs[$];
    longint m_sat[2];
    longint m_wrap[2];
    longint ms;
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            m_sat[c]  = 0;
            m_wrap[c] = 0;
        end
    endfunction

    function automatic void model_op(input longint a0, input longint a1, input longint dtv);
        exp_t   e;
        longint av[2];
        longint p, s;
        logic signed [31:0] t;
        av[0] = a0;
        av[1] = a1;
        for (int c = 0; c < 2; c++) begin
            p = av[c] * dtv;
            s = m_sat[c] + p;
            e.ovf_sat[c] = (s > MAXV) || (s < MINV);
            if (s > MAXV) s = MAXV;
            else if (s < MINV) s = MINV;
            m_sat[c] = s;
            s = m_wrap[c] + p;
            e.ovf_wrap[c] = (s > MAXV) || (s < MINV);
            t = s[31:0];
            m_wrap[c] = t;
        end
        e.v_sat  = {m_sat[1][31:0], m_sat[0][31:0]};
        e.v_wrap = {m_wrap[1][31:0], m_wrap[0][31:0]};
        sb.push_back(e);
    endfunction

    task automatic drive(input logic en, input logic clr, input longint a0, input longint a1,
                         input longint dtv);
        @(negedge clk);
        bus.enable = en;
        bus.clear  = clr;
        bus.a      = {a1[15:0], a0[15:0]};
        bus.dt     = dtv[15:0];
    endtask

    task automatic start(input string tag, input longint a0, input longint a1, input longint dtv,
                         input bit hold);
        drive(1'b1, 1'b0, a0, a1, dtv);
        model_op(a0, a1, dtv);
        @(posedge clk); #1;
        check({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
        if (!hold) bus.enable = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd34);
        if (bus.done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_v_sat"}, bus.v, e.v_sat);
            check({tag, "_ovf_sat"}, 64'(bus.ovf), 64'(e.ovf_sat));
            check({tag, "_v_wrap"}, busw.v, e.v_wrap);
            check({tag, "_ovf_wrap"}, 64'(busw.ovf), 64'(e.ovf_wrap));
            check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd1);
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          pulses;
        logic [31:0] t;
        longint      sa[2];

        rst = 1'b1;
        bus.enable = 1'b0; bus.clear = 1'b0; bus.a = '0; bus.dt = '0;
        bs.enable = 1'b0;  bs.clear = 1'b0;  bs.a = '0;  bs.dt = '0;
        model_clear();
        ms = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_v", bus.v, 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        // T1 basic
        start("t1", 3, -5, 10, 1'b0);
        wait_done("t1", 0);

        // T2 accumulate, then enable held across done
        start("t2a", 3, -5, 10, 1'b1);
        wait_done("t2a", 0);
        model_op(3, -5, 10);
        @(posedge clk); #1;
        check("t2_restart_busy", 64'(bus.busy), 64'd1);
        bus.enable = 1'b0;
        wait_done("t2b", 0);

        // T5 clear beats enable in IDLE
        drive(1'b1, 1'b1, 7, 7, 5);
        model_clear();
        @(posedge clk); #1;
        check("t5_clr_busy", 64'(bus.busy), 64'd0);
        check("t5_clr_v", bus.v, 64'd0);
        check("t5_clr_vw", busw.v, 64'd0);
        check("t5_clr_ovf", 64'(bus.ovf), 64'd0);
        bus.enable = 1'b0; bus.clear = 1'b0;

        // T5 clear/enable/new inputs while busy are ignored
        start("t5b", 3, -5, 10, 1'b0);
        drive(1'b1, 1'b1, 100, 100, 100);
        @(posedge clk); #1;
        bus.enable = 1'b0; bus.clear = 1'b0;
        wait_done("t5b", 1);

        // T3 saturation vs wrap, positive and negative limits
        drive(1'b0, 1'b1, 0, 0, 0);
        model_clear();
        @(posedge clk); #1;
        bus.clear = 1'b0;
        start("t3a", 32767, -32768, 65535, 1'b0);
        wait_done("t3a", 0);
        start("t3b", 32767, -32768, 65535, 1'b0);
        wait_done("t3b", 0);
        check("t3b_v0_sat_const", 64'(bus.v[31:0]), 64'h7FFF_FFFF);
        check("t3b_v0_wrap_const", 64'(busw.v[31:0]), 64'hFFFD_0002);
        start("t3c", 0, 0, 65535, 1'b0);
        wait_done("t3c", 0);

        // T4 reset on the 10th busy cycle
        start("t4", 3, -5, 10, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_v", bus.v, 64'd0);
        check("t4_vw", busw.v, 64'd0);
        check("t4_ovf", 64'(bus.ovf), 64'd0);
        sb.delete();
        model_clear();
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        check("t4_no_done", 64'(pulses), 64'd0);
        start("t4b", 3, -5, 10, 1'b0);
        wait_done("t4b", 0);

        // T6 fixed-point shift on the single-channel instance
        sa[0] = 16;
        sa[1] = -1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bs.a = sa[k][15:0];
            bs.dt = 16'd1;
            bs.enable = 1'b1;
            ms = ms + ((sa[k] * 1) >>> 4);
            sbs.push_back(ms);
            @(posedge clk); #1;
            bs.enable = 1'b0;
            n = 0;
            while (bs.done !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("t6_latency", 64'(n), 64'd17);
            if (sbs.size() > 0) begin
                ms = sbs.pop_front();
                t = ms[31:0];
                check("t6_v", 64'(bs.v), 64'(t));
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
